// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default parameters for the instruction fetch unit
package fetch_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          INSTR_W_DEF  = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - next program counter select: redirect target or sequential word
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_br_taken,
    input  logic [ADDR_W-1:0] i_br_target,
    output logic [ADDR_W-1:0] o_next_pc
);

    // PC counts words, so the sequential successor is +1 and wraps naturally
    assign o_next_pc = i_br_taken ? i_br_target : i_pc + ADDR_W'(1);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch with redirect and decode handshake
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_req_pc;
    logic               r_drop;
    logic               r_if_valid;
    logic [INSTR_W-1:0] r_if_instr;
    logic [ADDR_W-1:0]  r_if_pc;
    logic [ADDR_W-1:0]  w_next_pc;
    logic               w_accept;
    logic               w_load;
    logic               w_release;
    logic               w_drop_set;
    logic               w_drop_clr;

    fetch_next_pc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .i_pc        (r_pc),
        .i_br_taken  (br_taken),
        .i_br_target (br_target),
        .o_next_pc   (w_next_pc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_release   = 1'b0;
        w_drop_set  = 1'b0;
        w_drop_clr  = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    w_accept    = 1'b1;
                    w_drop_set  = br_taken;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    // a redirect arriving with the data makes that data stale too
                    if (r_drop || br_taken) begin
                        w_drop_clr  = 1'b1;
                        w_state_nxt = REQ;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else begin
                    w_drop_set = br_taken;
                end
            end
            HOLD: begin
                if (br_taken || id_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_drop     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (br_taken || w_accept) begin
                r_pc <= w_next_pc;
            end
            if (w_accept) begin
                r_req_pc <= r_pc;
            end
            if (w_drop_set) begin
                r_drop <= 1'b1;
            end else if (w_drop_clr) begin
                r_drop <= 1'b0;
            end
            if (w_load) begin
                r_if_valid <= 1'b1;
                r_if_instr <= imem_rsp_data;
                r_if_pc    <= r_req_pc;
            end else if (w_release) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign imem_req_valid = (r_state == REQ);
    assign imem_req_addr  = r_pc;
    assign if_valid       = r_if_valid;
    assign if_instr       = r_if_instr;
    assign if_pc          = r_if_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench with a transaction-level reference model for instr_fetch_unit
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid, br_taken, if_valid, id_ready;
    logic [31:0] imem_req_addr, br_target, if_pc, imem_rsp_data, if_instr;
    logic        req_valid2, if_valid2;
    logic [31:0] req_addr2, if_pc2, if_instr2;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int stall = 0;

    // reference model state: program order, memory in flight, words owed to decode
    word_t       deliv[$];
    word_t       dlog[$];
    int          dcyc[$];
    logic [31:0] rlog[$];
    logic [31:0] r2log[$];
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] fl_addr = 32'h0;
    bit          inflight = 0;
    bit          fl_stale = 0;
    int          cnt = 0;

    int          p_rdy, p_idr, p_br, lat_min, lat_max;
    bit          frc_br, frc_orphan, rand_orphan;
    logic [31:0] frc_tgt;
    int          phase = 0;
    bit          got2 = 0;
    logic [31:0] cap_pc2, cap_in2;

    always #5 clk = ~clk;

    instr_fetch_unit u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready)
    );

    instr_fetch_unit #(
        .RESET_PC (32'hFFFF_FFFF)
    ) u_dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (req_valid2),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (req_addr2),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .if_valid       (if_valid2),
        .if_instr       (if_instr2),
        .if_pc          (if_pc2),
        .id_ready       (id_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive();
        #1;
        imem_req_ready = ($urandom_range(0, 99) < p_rdy);
        id_ready       = ($urandom_range(0, 99) < p_idr);
        br_taken       = frc_br || ($urandom_range(0, 99) < p_br);
        if (frc_br) br_target = frc_tgt;
        else if ($urandom_range(0, 3) == 0) br_target = $urandom;
        else br_target = $urandom_range(0, 255);
        frc_br = 0;
        imem_rsp_valid = (cnt == 1);
        imem_rsp_data  = mem_word(fl_addr);
        if (!imem_rsp_valid && !inflight && (frc_orphan || (rand_orphan && $urandom_range(0, 9) == 0))) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end
        frc_orphan = 0;
    endtask

    task automatic cyc_step();
        @(negedge clk);
        drive();
    endtask

    // model update: every event is taken from the values present before the edge
    always @(posedge clk) begin
        bit had;
        cyc++;
        had = inflight;
        if (!rst_n) begin
            deliv.delete();
            inflight = 0;
            fl_stale = 0;
            cnt      = 0;
            exp_pc   = 32'h0;
        end else begin
            if (br_taken) deliv.delete();
            else if (id_ready && deliv.size() > 0) begin
                dlog.push_back(deliv[0]);
                dcyc.push_back(cyc);
                void'(deliv.pop_front());
            end
            if (imem_rsp_valid && had) begin
                if (!fl_stale && !br_taken) deliv.push_back({fl_addr, mem_word(fl_addr)});
                inflight = 0;
                cnt      = 0;
            end else if (cnt > 1) begin
                cnt--;
            end
            if (imem_req_valid && imem_req_ready) begin
                rlog.push_back(imem_req_addr);
                inflight = 1;
                fl_stale = 0;
                fl_addr  = exp_pc;
                exp_pc   = exp_pc + 32'd1;
                cnt      = $urandom_range(lat_min, lat_max);
            end
            if (req_valid2 && imem_req_ready) r2log.push_back(req_addr2);
            if (br_taken) begin
                exp_pc   = br_target;
                fl_stale = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 0;
            chk(if_valid === 1'b0, "rst_if_valid", if_valid, 0);
            chk(imem_req_valid === 1'b0, "rst_req_valid", imem_req_valid, 0);
            chk(if_pc === 32'h0 && if_instr === 32'h0, "rst_if_regs", {if_pc, if_instr}, 0);
        end else begin
            chk(if_valid === (deliv.size() != 0), "if_valid", if_valid, deliv.size() != 0);
            if (deliv.size() != 0) begin
                chk(if_pc === deliv[0].pc, "if_pc", if_pc, deliv[0].pc);
                chk(if_instr === deliv[0].instr, "if_instr", if_instr, deliv[0].instr);
            end
            if (imem_req_valid) begin
                chk(!inflight && deliv.size() == 0, "req_while_busy", inflight, 0);
                chk(imem_req_addr === exp_pc, "req_addr", imem_req_addr, exp_pc);
            end
            if (!imem_req_valid && !inflight && deliv.size() == 0) stall++;
            else stall = 0;
            chk(stall <= 1, "req_stall", stall, 1);
            chk(if_valid2 === if_valid && req_valid2 === imem_req_valid, "wrap_twin_ctrl",
                {if_valid2, req_valid2}, {if_valid, imem_req_valid});
            if (phase == 1 && if_valid2 && !got2) begin
                got2    = 1;
                cap_pc2 = if_pc2;
                cap_in2 = if_instr2;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] cap_pc, cap_in;
        int          n_req, n_del;
        bit          ok;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        br_taken = 0; br_target = 0; id_ready = 0;
        p_rdy = 100; p_idr = 100; p_br = 0; lat_min = 1; lat_max = 1;
        frc_br = 0; frc_tgt = 0; frc_orphan = 0; rand_orphan = 0;
        phase = 1;
        repeat (3) cyc_step();
        rst_n = 1'b1;

        // straight-line fetch, 1-cycle memory, decode always ready
        repeat (14) cyc_step();
        chk(rlog.size() >= 4 && dlog.size() >= 4, "t1_counts", dlog.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk(rlog[k] === 32'(k), "t1_req_addr", rlog[k], k);
            chk(dlog[k].pc === 32'(k), "t1_if_pc", dlog[k].pc, k);
            chk(dlog[k].instr === (32'hC0DE_0000 | 32'(k)), "t1_if_instr", dlog[k].instr, 32'hC0DE_0000 | k);
        end
        chk(dcyc[1] - dcyc[0] == 3 && dcyc[3] - dcyc[0] == 9, "t1_spacing", dcyc[1] - dcyc[0], 3);
        chk(r2log[0] === 32'hFFFF_FFFF && r2log[1] === 32'h0, "t5_wrap_addrs", {r2log[0], r2log[1]}, 64'hFFFF_FFFF_0000_0000);
        chk(got2 && cap_pc2 === 32'hFFFF_FFFF && cap_in2 === 32'hC0DE_0000, "t5_wrap_if", {cap_pc2, cap_in2}, 64'hFFFF_FFFF_C0DE_0000);
        phase = 0;

        // decode stalls for 5 cycles on a held word
        p_idr = 0;
        for (int i = 0; i < 20 && !if_valid; i++) cyc_step();
        chk(if_valid, "t2_reach_hold", if_valid, 1);
        cap_pc = if_pc;
        cap_in = if_instr;
        chk(cap_pc === 32'h4 && cap_in === 32'hC0DE_0004, "t2_held_word", {cap_pc, cap_in}, 64'h4_C0DE_0004);
        repeat (5) begin
            cyc_step();
            chk(if_valid && if_pc === cap_pc && if_instr === cap_in && !imem_req_valid, "t2_hold_stable", if_pc, cap_pc);
        end
        p_idr = 100;

        // redirect to 0x40 while a 3-cycle read is outstanding
        lat_min = 3; lat_max = 3;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (inflight && cnt > 1) begin ok = 1; break; end
            drive();
        end
        chk(ok, "t3_reach_wait", ok, 1);
        frc_br = 1; frc_tgt = 32'h40;
        n_req = rlog.size(); n_del = dlog.size();
        drive();
        for (int i = 0; i < 40 && dlog.size() == n_del; i++) cyc_step();
        chk(rlog[n_req] === 32'h40, "t3_next_req", rlog[n_req], 32'h40);
        chk(dlog[n_del].pc === 32'h40 && dlog[n_del].instr === 32'hC0DE_0040, "t3_next_pc", dlog[n_del].pc, 32'h40);

        // redirect to 0x10 in HOLD with decode ready: word is not consumed
        lat_min = 1; lat_max = 1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_valid) begin ok = 1; break; end
            drive();
        end
        chk(ok, "t4_reach_hold", ok, 1);
        frc_br = 1; frc_tgt = 32'h10;
        drive();
        @(negedge clk);
        chk(!if_valid, "t4_if_valid_dropped", if_valid, 0);
        chk(imem_req_valid && imem_req_addr === 32'h10, "t4_req_addr", imem_req_addr, 32'h10);
        drive();

        // reset during WAIT, stray responses afterwards are ignored
        lat_min = 3; lat_max = 3;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (inflight && cnt > 1) begin ok = 1; break; end
            drive();
        end
        chk(ok, "t6_reach_wait", ok, 1);
        drive();
        rst_n = 1'b0;
        repeat (2) cyc_step();
        @(negedge clk);
        frc_orphan = 1;
        drive();
        rst_n = 1'b1;
        n_req = rlog.size(); n_del = dlog.size();
        frc_orphan = 1;
        cyc_step();
        chk(!if_valid, "t6_orphan_ignored", if_valid, 0);
        for (int i = 0; i < 40 && dlog.size() == n_del; i++) cyc_step();
        chk(rlog[n_req] === 32'h0, "t6_first_req", rlog[n_req], 0);
        chk(dlog[n_del].pc === 32'h0 && dlog[n_del].instr === 32'hC0DE_0000, "t6_first_word", dlog[n_del].pc, 0);

        // randomized traffic: stalls on both sides, variable latency, redirects, stray responses
        p_rdy = 60; p_idr = 60; p_br = 8; lat_min = 1; lat_max = 4; rand_orphan = 1;
        repeat (3000) cyc_step();
        p_br = 0; rand_orphan = 0;
        repeat (10) cyc_step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
